// File: rtl/msx_bus_pkg.sv
// Shared types and constants for the MSX cartridge bus sequencer.
package msx_bus_pkg;

  localparam logic [1:0] OP_MEMRD = 2'b00;
  localparam logic [1:0] OP_MEMWR = 2'b01;
  localparam logic [1:0] OP_IORD  = 2'b10;
  localparam logic [1:0] OP_IOWR  = 2'b11;

  localparam logic [7:0] RDATA_IDLE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP
  } state_t;

  // Latched command from the SPI frontend
  typedef struct packed {
    logic [1:0]  op;
    logic        slot;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  // Registered cartridge-side pin values
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data_o;
    logic        data_oe;
    logic        rd_n;
    logic        wr_n;
    logic        iorq_n;
    logic        merq_n;
    logic        sltsl_n;
    logic        cs1_n;
    logic        cs2_n;
    logic        cs12_n;
  } pins_t;

  localparam pins_t PINS_RESET = '{
    addr: 16'h0000, data_o: 8'h00, data_oe: 1'b0,
    rd_n: 1'b1, wr_n: 1'b1, iorq_n: 1'b1, merq_n: 1'b1,
    sltsl_n: 1'b1, cs1_n: 1'b1, cs2_n: 1'b1, cs12_n: 1'b1
  };

  function automatic logic op_is_write(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic op_is_io(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/msx_bus_if.sv
// Command/response handshake plus MSX slot pins seen by the sequencer.
interface msx_bus_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_slot;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic [15:0] msx_addr;
  logic [7:0]  msx_data_o;
  logic        msx_data_oe;
  logic [7:0]  msx_data_i;
  logic        msx_rd_n;
  logic        msx_wr_n;
  logic        msx_iorq_n;
  logic        msx_merq_n;
  logic        msx_sltsl_n;
  logic        msx_cs1_n;
  logic        msx_cs2_n;
  logic        msx_cs12_n;
  logic        msx_m1_n;
  logic        msx_rfsh_n;
  logic        msx_wait_n;

  modport slave (
    input  cmd_valid, cmd_op, cmd_slot, cmd_addr, cmd_wdata, rsp_ready,
           msx_data_i, msx_wait_n,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, msx_addr, msx_data_o,
           msx_data_oe, msx_rd_n, msx_wr_n, msx_iorq_n, msx_merq_n, msx_sltsl_n,
           msx_cs1_n, msx_cs2_n, msx_cs12_n, msx_m1_n, msx_rfsh_n
  );

  modport master (
    output cmd_valid, cmd_op, cmd_slot, cmd_addr, cmd_wdata, rsp_ready,
           msx_data_i, msx_wait_n,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, msx_addr, msx_data_o,
           msx_data_oe, msx_rd_n, msx_wr_n, msx_iorq_n, msx_merq_n, msx_sltsl_n,
           msx_cs1_n, msx_cs2_n, msx_cs12_n, msx_m1_n, msx_rfsh_n
  );
endinterface

// File: rtl/msx_sync2.sv
// Two-flop synchronizer for asynchronous active-low cartridge inputs; idles high.
module msx_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  // Double-register the asynchronous input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/msx_bus_sequencer.sv
// Runs one frontend command as a timed MSX slot cycle: setup, strobe (+WAIT_n), hold, response.
module msx_bus_sequencer
  import msx_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned STROBE_CYC   = 4,
  parameter int unsigned HOLD_CYC     = 1,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input logic      clk,
  input logic      rst_n,
  msx_bus_if.slave bus
);
  localparam int unsigned CNT_W = 8;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] ext, ext_d;
  cmd_t             cmd_q, cmd_d;
  pins_t            pins_q, pins_d;
  logic             cmd_ready_q, rsp_valid_q, timeout_q, timeout_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             wait_s;
  logic             sel, active, is_wr, is_io;

  msx_sync2 u_wait_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.msx_wait_n),
    .q     (wait_s)
  );

  // Next state, shared phase counter, WAIT_n extension and response capture
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    ext_d     = ext;
    cmd_d     = cmd_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_d   = '{op: bus.cmd_op, slot: bus.cmd_slot,
                      addr: bus.cmd_addr, wdata: bus.cmd_wdata};
          cnt_d   = CNT_W'(SETUP_CYC);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt <= CNT_W'(1)) begin
          cnt_d   = CNT_W'(STROBE_CYC);
          ext_d   = '0;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt > CNT_W'(1)) begin
          cnt_d = cnt - CNT_W'(1);
        end else if (!wait_s && (ext < CNT_W'(WAIT_TIMEOUT))) begin
          ext_d = (ext == '1) ? ext : ext + CNT_W'(1);
        end else begin
          // Final strobe cycle: still waiting here means the extension budget ran out
          timeout_d = !wait_s;
          rdata_d   = (!wait_s || op_is_write(cmd_q.op)) ? RDATA_IDLE : bus.msx_data_i;
          cnt_d     = CNT_W'(HOLD_CYC);
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt <= CNT_W'(1)) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values for the upcoming state, so bus changes land one edge after the decision
  always_comb begin
    pins_d         = pins_q;
    sel            = (state_d == ST_SETUP) || (state_d == ST_STROBE);
    active         = sel || (state_d == ST_HOLD);
    is_wr          = op_is_write(cmd_d.op);
    is_io          = op_is_io(cmd_d.op);
    if (active) begin
      pins_d.addr = cmd_d.addr;
    end
    if (active && is_wr) begin
      pins_d.data_o = cmd_d.wdata;
    end
    pins_d.data_oe = active && is_wr;
    pins_d.rd_n    = !((state_d == ST_STROBE) && !is_wr);
    pins_d.wr_n    = !((state_d == ST_STROBE) && is_wr);
    pins_d.iorq_n  = !(sel && is_io);
    pins_d.merq_n  = !(sel && !is_io);
    pins_d.sltsl_n = !(sel && !is_io && cmd_d.slot);
    pins_d.cs1_n   = !(!pins_d.sltsl_n && (cmd_d.addr[15:14] == 2'b01));
    pins_d.cs2_n   = !(!pins_d.sltsl_n && (cmd_d.addr[15:14] == 2'b10));
    pins_d.cs12_n  = pins_d.cs1_n & pins_d.cs2_n;
  end

  // State and output registers; reset aborts any bus cycle immediately
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ext         <= '0;
      cmd_q       <= '0;
      pins_q      <= PINS_RESET;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= RDATA_IDLE;
      timeout_q   <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      ext         <= ext_d;
      cmd_q       <= cmd_d;
      pins_q      <= pins_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      rdata_q     <= rdata_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_timeout = timeout_q;
  assign bus.msx_addr    = pins_q.addr;
  assign bus.msx_data_o  = pins_q.data_o;
  assign bus.msx_data_oe = pins_q.data_oe;
  assign bus.msx_rd_n    = pins_q.rd_n;
  assign bus.msx_wr_n    = pins_q.wr_n;
  assign bus.msx_iorq_n  = pins_q.iorq_n;
  assign bus.msx_merq_n  = pins_q.merq_n;
  assign bus.msx_sltsl_n = pins_q.sltsl_n;
  assign bus.msx_cs1_n   = pins_q.cs1_n;
  assign bus.msx_cs2_n   = pins_q.cs2_n;
  assign bus.msx_cs12_n  = pins_q.cs12_n;
  assign bus.msx_m1_n    = 1'b1;
  assign bus.msx_rfsh_n  = 1'b1;
endmodule
